// File: rtl/q2_pkg.sv
// q2_pkg: shared definitions for the bit-serial ALU slice and its sequencer.
//   alu_op_e : operation codes driven onto the slice select lines {o1,o0}
//   state_e  : control FSM states of q2_alu_seq
package q2_pkg;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_NOR  = 2'b01,
        ALU_ADD  = 2'b10,
        ALU_SHR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/q2_alu.sv
// q2_alu: combinational 1-bit ALU slice.
//   a, x0  : current bits of operands A and X
//   x1     : next-higher bit of X (shift source)
//   f      : chain flag in (carry for ADD, zero-so-far for PASS/NOR,
//            shifted-out bit for SHR)
//   o1, o0 : operation select (see q2_pkg::alu_op_e)
//   r      : result bit
//   fo     : chain flag out
module q2_alu (
    input  logic a,
    input  logic x0,
    input  logic x1,
    input  logic f,
    input  logic o1,
    input  logic o0,
    output logic r,
    output logic fo
);

    always_comb begin
        r  = 1'b0;
        fo = 1'b0;
        case ({o1, o0})
            2'b00: begin
                r  = x0;
                fo = f & ~x0;
            end
            2'b01: begin
                r  = ~(a | x0);
                fo = f & (a | x0);
            end
            2'b10: begin
                r  = a ^ x0 ^ f;
                fo = (a & x0) | (a & f) | (x0 & f);
            end
            default: begin
                // Shift: flag already holds x_in[0], just carry it along.
                r  = x1;
                fo = f;
            end
        endcase
    end

endmodule

// File: rtl/q2_alu_seq.sv
// q2_alu_seq: bit-serial sequencer around a single q2_alu slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an operation (accepted in IDLE or DONE)
//   op         : operation code (q2_pkg::alu_op_e encoding)
//   a_in, x_in : operands, latched on accept
//   cin        : ADD carry-in / SHR fill bit, latched on accept
//   busy       : high while RUN
//   done       : one-cycle pulse when result/flag become valid
//   result     : result word, held until the next completion
//   flag       : carry-out (ADD), zero (PASS/NOR), shifted-out bit (SHR)
module q2_alu_seq
    import q2_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state;
    alu_op_e          op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-2:0] res_sh;
    logic             cin_q;
    logic             f_q;

    logic             slice_x1;
    logic             slice_r;
    logic             slice_fo;
    logic [WIDTH-1:0] res_nxt;
    logic             accept;

    // On the MSB step there is no next X bit; feed the fill bit instead.
    assign slice_x1 = (cnt == CNT_LAST) ? cin_q : x_sh[1];
    // Partial result shifts in from the top; after WIDTH steps bit 0 lands at 0.
    assign res_nxt  = {slice_r, res_sh};
    assign accept   = start && (state == ST_IDLE || state == ST_DONE);

    q2_alu u_alu (
        .a  (a_sh[0]),
        .x0 (x_sh[0]),
        .x1 (slice_x1),
        .f  (f_q),
        .o1 (op_q[1]),
        .o0 (op_q[0]),
        .r  (slice_r),
        .fo (slice_fo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= ALU_PASS;
            cnt    <= '0;
            a_sh   <= '0;
            x_sh   <= '0;
            res_sh <= '0;
            cin_q  <= 1'b0;
            f_q    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flag   <= 1'b0;
        end else if (accept) begin
            state  <= ST_RUN;
            op_q   <= alu_op_e'(op);
            cnt    <= '0;
            a_sh   <= a_in;
            x_sh   <= x_in;
            cin_q  <= cin;
            busy   <= 1'b1;
            done   <= 1'b0;
            case (alu_op_e'(op))
                ALU_ADD: f_q <= cin;
                ALU_SHR: f_q <= x_in[0];
                default: f_q <= 1'b1;
            endcase
        end else begin
            case (state)
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    x_sh   <= x_sh >> 1;
                    res_sh <= res_nxt[WIDTH-1:1];
                    f_q    <= slice_fo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= res_nxt;
                        flag   <= slice_fo;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
